// File: rtl/pipelined_shifter.sv
// pipelined_shifter
//   Pipelined barrel shifter: shifts a WIDTH-bit operand right/left/rotate by
//   0..WIDTH-1 in one of four modes, with the log2(WIDTH) shift levels spread
//   over STAGES register stages. Valid/ready handshake on both sides; one
//   operation per cycle when not stalled.
//
//   Optional build macro: SHIFTER_FLAGS_EN
//     defined   -> out_zero / out_carry computed and carried with each item
//     undefined -> no flag logic, out_zero / out_carry tied 0
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand/amount/mode valid
//   in_ready   block can accept this cycle
//   in_data    operand (WIDTH)
//   in_amt     shift amount (log2(WIDTH)), unsigned
//   in_mode    00 SLL, 01 SRA, 10 ROR, 11 SRL
//   out_valid  result valid
//   out_ready  consumer accepts result
//   out_data   shifted result (WIDTH)
//   out_zero   result == 0 (flags build only)
//   out_carry  last bit shifted out (flags build only)

module pipelined_shifter #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   input  logic [$clog2(WIDTH)-1:0] in_amt,
   input  logic [1:0]               in_mode,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_zero,
   output logic                     out_carry
);

   localparam int AW  = $clog2(WIDTH);
   // levels per stage; level k lives in stage k/LPS, so the last stage
   // naturally gets whatever remains
   localparam int LPS = (AW + STAGES - 1) / STAGES;

   localparam logic [1:0] MODE_SLL = 2'b00;
   localparam logic [1:0] MODE_SRA = 2'b01;
   localparam logic [1:0] MODE_ROR = 2'b10;

   function automatic logic [WIDTH-1:0] shift_level(
      input logic [WIDTH-1:0] d,
      input logic [1:0]       mode,
      input logic             msb,
      input int               sh
   );
      logic [WIDTH-1:0] fill;
      logic [WIDTH-1:0] r;
      fill = ~({WIDTH{1'b1}} >> sh);
      case (mode)
         MODE_SLL: r = d << sh;
         // fill with the original operand MSB, not the partial result's MSB
         MODE_SRA: r = (d >> sh) | (msb ? fill : '0);
         MODE_ROR: r = (d >> sh) | (d << (WIDTH - sh));
         default:  r = d >> sh;
      endcase
      return r;
   endfunction

   logic [WIDTH-1:0] data_q [STAGES];
   logic [AW-1:0]    amt_q  [STAGES];
   logic [1:0]       mode_q [STAGES];
   logic [STAGES-1:0] msb_q;
   logic [STAGES-1:0] vld_q;
   logic [STAGES-1:0] adv;

   logic [WIDTH-1:0] src_data [STAGES];
   logic [AW-1:0]    src_amt  [STAGES];
   logic [1:0]       src_mode [STAGES];
   logic [WIDTH-1:0] nxt_data [STAGES];
   logic [STAGES-1:0] src_msb;
   logic [STAGES-1:0] src_vld;

   always_comb begin
      logic [WIDTH-1:0] acc;
      acc      = '0;
      src_data = '{default: '0};
      src_amt  = '{default: '0};
      src_mode = '{default: '0};
      nxt_data = '{default: '0};
      src_msb  = '0;
      src_vld  = '0;

      src_data[0] = in_data;
      src_amt[0]  = in_amt;
      src_mode[0] = in_mode;
      src_msb[0]  = in_data[WIDTH-1];
      src_vld[0]  = in_valid;
      for (int s = 1; s < STAGES; s++) begin
         src_data[s] = data_q[s-1];
         src_amt[s]  = amt_q[s-1];
         src_mode[s] = mode_q[s-1];
         src_msb[s]  = msb_q[s-1];
         src_vld[s]  = vld_q[s-1];
      end

      for (int s = 0; s < STAGES; s++) begin
         acc = src_data[s];
         for (int k = 0; k < AW; k++) begin
            if ((k / LPS) == s && src_amt[s][k])
               acc = shift_level(acc, src_mode[s], src_msb[s], 1 << k);
         end
         nxt_data[s] = acc;
      end
   end

   // A stage advances if it or any stage downstream of it is empty, or the
   // consumer is taking the head item. Closed form avoids a comb chain loop.
   for (genvar s = 0; s < STAGES; s++) begin : g_adv
      assign adv[s] = out_ready | ~(&vld_q[STAGES-1:s]);
   end

   assign in_ready  = adv[0];
   assign out_valid = vld_q[STAGES-1];
   assign out_data  = data_q[STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         msb_q <= '0;
         for (int s = 0; s < STAGES; s++) begin
            data_q[s] <= '0;
            amt_q[s]  <= '0;
            mode_q[s] <= '0;
         end
      end else begin
         for (int s = 0; s < STAGES; s++) begin
            if (adv[s]) begin
               vld_q[s] <= src_vld[s];
               // payload only moves with a real item, so a bubble never
               // disturbs what a stalled output is showing
               if (src_vld[s]) begin
                  data_q[s] <= nxt_data[s];
                  amt_q[s]  <= src_amt[s];
                  mode_q[s] <= src_mode[s];
                  msb_q[s]  <= src_msb[s];
               end
            end
         end
      end
   end

`ifdef SHIFTER_FLAGS_EN
   logic [STAGES-1:0] carry_q;
   logic [STAGES-1:0] src_carry;
   logic              zero_q;
   logic [AW-1:0]     sll_idx;
   logic [AW-1:0]     sr_idx;
   logic              in_carry;

   // ROR's carry is out_data[MSB], which is in_data[amt-1] -- same as SRA/SRL,
   // so every carry is known up front and just rides along with the item.
   always_comb begin
      sll_idx  = '0 - in_amt;
      sr_idx   = in_amt - {{(AW-1){1'b0}}, 1'b1};
      in_carry = 1'b0;
      if (in_amt != '0)
         in_carry = (in_mode == MODE_SLL) ? in_data[sll_idx] : in_data[sr_idx];
   end

   always_comb begin
      src_carry    = '0;
      src_carry[0] = in_carry;
      for (int s = 1; s < STAGES; s++)
         src_carry[s] = carry_q[s-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         carry_q <= '0;
         zero_q  <= 1'b0;
      end else begin
         for (int s = 0; s < STAGES; s++) begin
            if (adv[s] && src_vld[s])
               carry_q[s] <= src_carry[s];
         end
         if (adv[STAGES-1] && src_vld[STAGES-1])
            zero_q <= (nxt_data[STAGES-1] == '0);
      end
   end

   assign out_zero  = zero_q;
   assign out_carry = carry_q[STAGES-1];
`else
   assign out_zero  = 1'b0;
   assign out_carry = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_shifter.sv
module tb_pipelined_shifter;

`ifdef SHIFTER_FLAGS_EN
   localparam bit FLAGS = 1'b1;
`else
   localparam bit FLAGS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // WIDTH=16, STAGES=2
   logic        v16 = 1'b0, r16, ov16, ordy16 = 1'b1, z16, c16;
   logic [15:0] d16 = '0, od16;
   logic [3:0]  a16 = '0;
   logic [1:0]  m16 = '0;

   // WIDTH=32, shared inputs, STAGES=1 (a) and STAGES=5 (b)
   logic        v32 = 1'b0, ordy32 = 1'b1;
   logic [31:0] d32 = '0;
   logic [4:0]  a32 = '0;
   logic [1:0]  m32 = '0;
   logic        ir32a, ov32a, z32a, c32a, ir32b, ov32b, z32b, c32b;
   logic [31:0] od32a, od32b;

   int errors = 0;
   int checks = 0;

   pipelined_shifter #(.WIDTH(16), .STAGES(2)) u16 (
      .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16), .in_data(d16),
      .in_amt(a16), .in_mode(m16), .out_valid(ov16), .out_ready(ordy16),
      .out_data(od16), .out_zero(z16), .out_carry(c16));

   pipelined_shifter #(.WIDTH(32), .STAGES(1)) u32a (
      .clk(clk), .rst(rst), .in_valid(v32), .in_ready(ir32a), .in_data(d32),
      .in_amt(a32), .in_mode(m32), .out_valid(ov32a), .out_ready(ordy32),
      .out_data(od32a), .out_zero(z32a), .out_carry(c32a));

   pipelined_shifter #(.WIDTH(32), .STAGES(5)) u32b (
      .clk(clk), .rst(rst), .in_valid(v32), .in_ready(ir32b), .in_data(d32),
      .in_amt(a32), .in_mode(m32), .out_valid(ov32b), .out_ready(ordy32),
      .out_data(od32b), .out_zero(z32b), .out_carry(c32b));

   function automatic logic [63:0] ref_shift(input logic [63:0] d, input int a,
                                             input logic [1:0] m, input int w);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < w; i++) begin
         case (m)
            2'b00:   r[i] = (i >= a) ? d[i-a] : 1'b0;
            2'b01:   r[i] = (i + a < w) ? d[i+a] : d[w-1];
            2'b10:   r[i] = d[(i+a) % w];
            default: r[i] = (i + a < w) ? d[i+a] : 1'b0;
         endcase
      end
      return r;
   endfunction

   function automatic logic ref_carry(input logic [63:0] d, input int a,
                                      input logic [1:0] m, input int w);
      if (a == 0) return 1'b0;
      if (m == 2'b00) return d[w-a];
      return d[a-1];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      v16 = 1'b1; d16 = 16'hFFFF; a16 = 4'd1; m16 = 2'b00;
      tick();
      tick();
      rst = 1'b0;
      v16 = 1'b0;
      #1;
      checks++; if (ov16 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", ov16); end
      checks++; if (od16 !== 16'h0000) begin errors++; $display("FAIL reset_out_data: got %h expected 0000", od16); end
      checks++; if (r16 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", r16); end
      checks++; if ({z16, c16} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {z16, c16}); end
      checks++; if ({ov32a, ov32b} !== 2'b00) begin errors++; $display("FAIL reset_out_valid_32: got %b expected 00", {ov32a, ov32b}); end
   endtask

   task automatic test_modes();
      logic [15:0] md [4] = '{16'h0001, 16'h8000, 16'h8000, 16'h1234};
      logic [3:0]  ma [4] = '{4'd15, 4'd4, 4'd15, 4'd4};
      logic [1:0]  mm [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
      logic [15:0] me [4] = '{16'h8000, 16'hF800, 16'h0001, 16'h4123};
      for (int cyc = 0; cyc < 8; cyc++) begin
         tick();
         ordy16 = 1'b1;
         if (cyc < 4) begin
            v16 = 1'b1; d16 = md[cyc]; a16 = ma[cyc]; m16 = mm[cyc];
         end else v16 = 1'b0;
         #1;
         if (cyc < 4) begin
            checks++; if (r16 !== 1'b1) begin errors++; $display("FAIL modes_in_ready cyc%0d: got %b expected 1", cyc, r16); end
         end
         checks++;
         if (ov16 !== (cyc >= 2 && cyc < 6)) begin
            errors++; $display("FAIL modes_out_valid cyc%0d: got %b expected %b", cyc, ov16, (cyc >= 2 && cyc < 6));
         end
         if (cyc >= 2 && cyc < 6) begin
            checks++; if (od16 !== me[cyc-2]) begin errors++; $display("FAIL modes_data item%0d: got %h expected %h", cyc-2, od16, me[cyc-2]); end
         end
      end
   endtask

   task automatic test_amt_zero();
      for (int cyc = 0; cyc < 7; cyc++) begin
         tick();
         ordy16 = 1'b1;
         if (cyc < 4) begin
            v16 = 1'b1; d16 = 16'hA5A5; a16 = 4'd0; m16 = cyc[1:0];
         end else v16 = 1'b0;
         #1;
         checks++;
         if (ov16 !== (cyc >= 2 && cyc < 6)) begin
            errors++; $display("FAIL amt0_out_valid cyc%0d: got %b expected %b", cyc, ov16, (cyc >= 2 && cyc < 6));
         end
         if (cyc >= 2 && cyc < 6) begin
            checks++; if (od16 !== 16'hA5A5) begin errors++; $display("FAIL amt0_data mode%0d: got %h expected a5a5", cyc-2, od16); end
            checks++; if ({z16, c16} !== 2'b00) begin errors++; $display("FAIL amt0_flags mode%0d: got %b expected 00", cyc-2, {z16, c16}); end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] bd [4] = '{16'h0003, 16'hF000, 16'h000F, 16'h4000};
      logic [3:0]  ba [4] = '{4'd1, 4'd8, 4'd4, 4'd2};
      logic [1:0]  bm [4] = '{2'b00, 2'b11, 2'b10, 2'b01};
      logic [15:0] be [4] = '{16'h0006, 16'h00F0, 16'hF000, 16'h1000};
      int sent = 0;
      int rcv  = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         tick();
         ordy16 = !(cyc >= 3 && cyc < 6);
         if (sent < 4) begin
            v16 = 1'b1; d16 = bd[sent]; a16 = ba[sent]; m16 = bm[sent];
         end else v16 = 1'b0;
         #1;
         if (cyc >= 3 && cyc < 6) begin
            checks++; if (r16 !== 1'b0) begin errors++; $display("FAIL bp_in_ready_stall cyc%0d: got %b expected 0", cyc, r16); end
            checks++; if (ov16 !== 1'b1) begin errors++; $display("FAIL bp_out_valid_stall cyc%0d: got %b expected 1", cyc, ov16); end
            checks++; if (od16 !== be[1]) begin errors++; $display("FAIL bp_hold_data cyc%0d: got %h expected %h", cyc, od16, be[1]); end
         end
         if (ov16 && ordy16) begin
            checks++;
            if (rcv >= 4) begin
               errors++; $display("FAIL bp_extra_output: got %h expected none", od16);
            end else if (od16 !== be[rcv]) begin
               errors++; $display("FAIL bp_order item%0d: got %h expected %h", rcv, od16, be[rcv]);
            end
            rcv++;
         end
         if (v16 && r16) sent++;
      end
      checks++; if (rcv != 4) begin errors++; $display("FAIL bp_count: got %0d expected 4", rcv); end
      checks++; if (ov16 !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b expected 0", ov16); end
   endtask

   task automatic test_reset_mid();
      for (int cyc = 0; cyc < 8; cyc++) begin
         tick();
         rst = (cyc == 2);
         ordy16 = (cyc != 2);
         case (cyc)
            0: begin v16 = 1'b1; d16 = 16'h0001; a16 = 4'd1; m16 = 2'b00; end
            1: begin v16 = 1'b1; d16 = 16'h00FF; a16 = 4'd4; m16 = 2'b00; end
            2: begin v16 = 1'b1; d16 = 16'h7777; a16 = 4'd0; m16 = 2'b11; end
            4: begin v16 = 1'b1; d16 = 16'h0100; a16 = 4'd4; m16 = 2'b11; end
            default: v16 = 1'b0;
         endcase
         #1;
         if (cyc == 3) begin
            checks++; if (ov16 !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b expected 0", ov16); end
            checks++; if (od16 !== 16'h0000) begin errors++; $display("FAIL rstmid_out_data: got %h expected 0000", od16); end
            checks++; if (r16 !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b expected 1", r16); end
         end
         if (cyc == 4 || cyc == 5 || cyc == 7) begin
            checks++; if (ov16 !== 1'b0) begin errors++; $display("FAIL rstmid_idle cyc%0d: got %b expected 0", cyc, ov16); end
         end
         if (cyc == 6) begin
            checks++; if (ov16 !== 1'b1) begin errors++; $display("FAIL rstmid_new_valid: got %b expected 1", ov16); end
            checks++; if (od16 !== 16'h0010) begin errors++; $display("FAIL rstmid_new_data: got %h expected 0010", od16); end
         end
      end
   endtask

   task automatic test_flags();
      logic [15:0] fd [2] = '{16'h8001, 16'h0001};
      logic [1:0]  fm [2] = '{2'b00, 2'b11};
      logic [15:0] fe [2] = '{16'h0002, 16'h0000};
      logic        fz [2] = '{1'b0, 1'b1};
      for (int cyc = 0; cyc < 5; cyc++) begin
         tick();
         ordy16 = 1'b1;
         if (cyc < 2) begin
            v16 = 1'b1; d16 = fd[cyc]; a16 = 4'd1; m16 = fm[cyc];
         end else v16 = 1'b0;
         #1;
         if (cyc >= 2 && cyc < 4) begin
            checks++; if (ov16 !== 1'b1) begin errors++; $display("FAIL flags_valid item%0d: got %b expected 1", cyc-2, ov16); end
            checks++; if (od16 !== fe[cyc-2]) begin errors++; $display("FAIL flags_data item%0d: got %h expected %h", cyc-2, od16, fe[cyc-2]); end
            checks++; if (c16 !== FLAGS) begin errors++; $display("FAIL flags_carry item%0d: got %b expected %b", cyc-2, c16, FLAGS); end
            checks++; if (z16 !== (FLAGS & fz[cyc-2])) begin errors++; $display("FAIL flags_zero item%0d: got %b expected %b", cyc-2, z16, FLAGS & fz[cyc-2]); end
         end
      end
   endtask

   task automatic test_sweep();
      localparam int N = 24;
      logic [31:0] sd [N];
      int          sa [N];
      logic [1:0]  sm [N];
      logic [63:0] exp_d;
      logic        exp_c;
      for (int i = 0; i < N; i++) begin
         sd[i] = $urandom();
         sa[i] = $urandom_range(0, 31);
         sm[i] = 2'($urandom_range(0, 3));
      end
      sd[0] = 32'h0000_0001; sa[0] = 1; sm[0] = 2'b11;
      for (int cyc = 0; cyc < N + 7; cyc++) begin
         tick();
         ordy32 = 1'b1;
         if (cyc < N) begin
            v32 = 1'b1; d32 = sd[cyc]; a32 = 5'(sa[cyc]); m32 = sm[cyc];
         end else v32 = 1'b0;
         #1;
         if (cyc < N) begin
            checks++; if ({ir32a, ir32b} !== 2'b11) begin errors++; $display("FAIL sweep_in_ready cyc%0d: got %b expected 11", cyc, {ir32a, ir32b}); end
         end
         // STAGES=1
         checks++;
         if (ov32a !== (cyc >= 1 && cyc < N + 1)) begin
            errors++; $display("FAIL sweep_s1_valid cyc%0d: got %b expected %b", cyc, ov32a, (cyc >= 1 && cyc < N + 1));
         end
         if (cyc >= 1 && cyc < N + 1) begin
            exp_d = ref_shift({32'h0, sd[cyc-1]}, sa[cyc-1], sm[cyc-1], 32);
            exp_c = FLAGS & ref_carry({32'h0, sd[cyc-1]}, sa[cyc-1], sm[cyc-1], 32);
            checks++; if (od32a !== exp_d[31:0]) begin errors++; $display("FAIL sweep_s1_data item%0d: got %h expected %h", cyc-1, od32a, exp_d[31:0]); end
            checks++; if ({z32a, c32a} !== {FLAGS & (exp_d == 0), exp_c}) begin errors++; $display("FAIL sweep_s1_flags item%0d: got %b expected %b", cyc-1, {z32a, c32a}, {FLAGS & (exp_d == 0), exp_c}); end
         end
         // STAGES=5
         checks++;
         if (ov32b !== (cyc >= 5 && cyc < N + 5)) begin
            errors++; $display("FAIL sweep_s5_valid cyc%0d: got %b expected %b", cyc, ov32b, (cyc >= 5 && cyc < N + 5));
         end
         if (cyc >= 5 && cyc < N + 5) begin
            exp_d = ref_shift({32'h0, sd[cyc-5]}, sa[cyc-5], sm[cyc-5], 32);
            exp_c = FLAGS & ref_carry({32'h0, sd[cyc-5]}, sa[cyc-5], sm[cyc-5], 32);
            checks++; if (od32b !== exp_d[31:0]) begin errors++; $display("FAIL sweep_s5_data item%0d: got %h expected %h", cyc-5, od32b, exp_d[31:0]); end
            checks++; if ({z32b, c32b} !== {FLAGS & (exp_d == 0), exp_c}) begin errors++; $display("FAIL sweep_s5_flags item%0d: got %b expected %b", cyc-5, {z32b, c32b}, {FLAGS & (exp_d == 0), exp_c}); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_modes();
      test_amt_zero();
      test_backpressure();
      test_reset_mid();
      test_flags();
      test_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
